// File: rtl/key_reader.sv
// key_reader: unlocks a serial key responder with a four-step bus sequence, then shifts in an NBITS key MSB-first and compares it to EXPECT.
// Optional build macro KEY_READER_RETRY_EN: a mismatching key triggers one full UNLOCK+READ rerun before done is reported.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start             request one key-read sequence (ignored unless idle)
//   SSER              active-low responder select
//   BA13, BA12        responder window address bits
//   BA_SEL[3:0]       step code on BA7..BA4
//   BR_W              bus direction, always read (1)
//   SDRD              serial key bit from the responder
//   busy              sequence in progress
//   done              one-clock completion pulse
//   match             key equals EXPECT, held until the next accepted start
//   key[NBITS-1:0]    assembled key
module key_reader #(
  parameter int NBITS = 16,
  parameter int CYC_LEN = 4,
  parameter logic [NBITS-1:0] EXPECT = 16'hA5C3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             SSER,
  output logic             BA13,
  output logic             BA12,
  output logic [3:0]       BA_SEL,
  output logic             BR_W,
  input  logic             SDRD,
  output logic             busy,
  output logic             done,
  output logic             match,
  output logic [NBITS-1:0] key
);
  typedef enum logic [2:0] {IDLE, UNLOCK, READ, GAP, FINISH} state_t;
  // unlock step codes, step 0 in the low nibble
  localparam logic [15:0] UNLOCK_SEL = {4'b1001, 4'b1010, 4'b1000, 4'b0010};
  // steps 0..3 are unlock cycles, 4..NBITS+3 are key-bit reads
  localparam logic [5:0] LAST = 6'(NBITS + 3);
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [5:0] step, step_n;
  logic [NBITS-1:0] key_n;
  logic match_n, busy_n, done_n, active_n;
`ifdef KEY_READER_RETRY_EN
  logic tried, tried_n;
`endif
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    step_n = step;
    key_n = key;
    match_n = match;
    busy_n = busy;
    done_n = 1'b0;
`ifdef KEY_READER_RETRY_EN
    tried_n = tried;
`endif
    case (state)
      IDLE: if (start) begin
        state_n = UNLOCK;
        cnt_n = '0;
        step_n = '0;
        key_n = '0;
        match_n = 1'b0;
        busy_n = 1'b1;
`ifdef KEY_READER_RETRY_EN
        tried_n = 1'b0;
`endif
      end
      UNLOCK, READ: begin
        cnt_n = cnt + 4'd1;
        if (cnt == 4'(CYC_LEN - 1)) begin
          state_n = GAP;
          cnt_n = '0;
          // SDRD is only captured on the closing clock of a read cycle
          if (state == READ) key_n = NBITS'({key, SDRD});
        end
      end
      GAP: begin
        step_n = step + 6'd1;
        state_n = (step < 6'd3) ? UNLOCK : READ;
        if (step == LAST) begin
`ifdef KEY_READER_RETRY_EN
          // the final gap doubles as the gap before the rerun
          if (key != EXPECT && !tried) begin
            state_n = UNLOCK;
            step_n = '0;
            key_n = '0;
            tried_n = 1'b1;
          end else state_n = FINISH;
`else
          state_n = FINISH;
`endif
        end
      end
      FINISH: begin
        state_n = IDLE;
        done_n = 1'b1;
        match_n = (key == EXPECT);
        busy_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
    active_n = (state_n == UNLOCK) || (state_n == READ);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      step <= '0;
      key <= '0;
      match <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      SSER <= 1'b1;
      BA13 <= 1'b1;
      BA12 <= 1'b0;
      BA_SEL <= '0;
      BR_W <= 1'b1;
`ifdef KEY_READER_RETRY_EN
      tried <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      step <= step_n;
      key <= key_n;
      match <= match_n;
      busy <= busy_n;
      done <= done_n;
      // bus pins are registered from the next state so they line up with it
      SSER <= !active_n;
      BA13 <= !active_n;
      BA12 <= active_n;
      BA_SEL <= (state_n == UNLOCK) ? UNLOCK_SEL[step_n[1:0]*4 +: 4] : 4'b0000;
      BR_W <= 1'b1;
`ifdef KEY_READER_RETRY_EN
      tried <= tried_n;
`endif
    end
  end
endmodule

// File: tb/tb_key_reader.sv
// tb_key_reader: randomized responder-driven bench for key_reader against a sequence-level model.
module tb_key_reader;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, start2 = 1'b0, SDRD = 1'b0;
  logic SSER, BA13, BA12, BR_W, busy, done, match;
  logic [3:0] BA_SEL;
  logic [15:0] key;
  logic sser2, ba13_2, ba12_2, br_w2, busy2, done2, match2;
  logic [3:0] ba_sel2;
  logic [0:0] key2;
  int total = 0, bad = 0, bus_err = 0;
  logic [15:0] resp = 16'h0;
  int sel_q[$], len_q[$], gap_q[$];
  bit retry;
  always #5 clk = ~clk;
  key_reader dut (
    .clk(clk), .rst(rst), .start(start), .SSER(SSER), .BA13(BA13), .BA12(BA12),
    .BA_SEL(BA_SEL), .BR_W(BR_W), .SDRD(SDRD), .busy(busy), .done(done),
    .match(match), .key(key)
  );
  key_reader #(.NBITS(1), .CYC_LEN(2), .EXPECT(1'b1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .SSER(sser2), .BA13(ba13_2), .BA12(ba12_2),
    .BA_SEL(ba_sel2), .BR_W(br_w2), .SDRD(1'b1), .busy(busy2), .done(done2),
    .match(match2), .key(key2)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // responder: serves resp MSB-first on read cycles, noise elsewhere; also logs bus cycles
  initial begin
    int cyc = 0, hi = 0, k;
    logic ps = 1'b1, pb = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (busy && !pb) begin
          sel_q.delete();
          len_q.delete();
          gap_q.delete();
          hi = 0;
        end
        if (!busy) cyc = 0;
        else if (ps && !SSER) cyc++;
        if (!SSER) begin
          if (ps) begin
            if (sel_q.size() > 0) gap_q.push_back(hi);
            sel_q.push_back(int'(BA_SEL));
            len_q.push_back(0);
            hi = 0;
          end
          len_q[len_q.size()-1] = len_q[len_q.size()-1] + 1;
          if (BA13 || !BA12 || !BR_W || int'(BA_SEL) != sel_q[sel_q.size()-1]) bus_err++;
        end else begin
          hi++;
          if (!BA13 || BA12 || BA_SEL != 4'd0 || !BR_W) bus_err++;
        end
        k = (cyc - 1) % 20;
        SDRD = (busy && !SSER && k >= 4) ? resp[19-k] : 1'($urandom);
        ps = SSER;
        pb = busy;
      end
    end
  end
  task automatic check_bus(input int passes);
    int exp_sel[$];
    int e = 0;
    for (int p = 0; p < passes; p++) begin
      exp_sel.push_back(2);
      exp_sel.push_back(8);
      exp_sel.push_back(10);
      exp_sel.push_back(9);
      for (int i = 0; i < 16; i++) exp_sel.push_back(0);
    end
    check("bus_runs", sel_q.size(), exp_sel.size());
    check("bus_gaps", gap_q.size(), exp_sel.size() - 1);
    for (int i = 0; i < sel_q.size(); i++) if (i >= exp_sel.size() || sel_q[i] != exp_sel[i]) e++;
    for (int i = 0; i < len_q.size(); i++) if (len_q[i] != 4) e++;
    for (int i = 0; i < gap_q.size(); i++) if (gap_q[i] != 1) e++;
    check("bus_seq", e, 0);
  endtask
  task automatic run_seq(input logic [15:0] r, input bit poke);
    int n = 0;
    bit ok, mm;
    ok = (r == 16'hA5C3);
    mm = retry && !ok;
    resp = r;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("key_clr", key, 0);
    check("busy_on", busy, 1);
    check("match_clr", match, 0);
    while (!done && n < 500) begin
      @(posedge clk);
      #1;
      n++;
      start = poke && n == 50;
    end
    start = 1'b0;
    check("latency", n, mm ? 201 : 101);
    check("key", key, r);
    check("match", match, ok);
    check_bus(mm ? 2 : 1);
    @(posedge clk);
    #1;
    check("done_pulse", done, 0);
    check("busy_after", busy, 0);
    check("match_hold", match, ok);
  endtask
  initial begin
    int n;
    int dq[$];
`ifdef KEY_READER_RETRY_EN
    retry = 1'b1;
`else
    retry = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_bus", {SSER, BA13, BA12, BA_SEL, BR_W}, 8'b1100_0001);
    check("rst_flags", {busy, done, match}, 0);
    check("rst_key", key, 0);
    @(negedge clk) rst = 1'b0;
    run_seq(16'hA5C3, 1'b0);
    run_seq(16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) run_seq(16'($urandom), 1'b1);
    run_seq(16'hA5C3, 1'b1);
    resp = 16'hA5C3;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (36) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_bus", {SSER, BA12, BA13}, 3'b101);
    check("mid_rst_flags", {busy, done, match}, 0);
    check("mid_rst_key", key, 0);
    @(negedge clk) rst = 1'b0;
    run_seq(16'hA5C3, 1'b0);
    resp = 16'hA5C3;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1;
    for (n = 1; n <= 310; n++) begin
      @(posedge clk);
      #1;
      if (done) dq.push_back(n);
    end
    start = 1'b0;
    check("held_count", dq.size(), 3);
    if (dq.size() == 3) begin
      check("held_d0", dq[0], 101);
      check("held_d1", dq[1], 203);
      check("held_d2", dq[2], 305);
    end
    repeat (110) @(posedge clk);
    @(negedge clk) start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    n = 0;
    while (!done2 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("small_latency", n, 16);
    check("small_key", key2, 1);
    check("small_match", match2, 1);
    check("bus_err", bus_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/key_reader.md
KEY_READER -- requirements
Module: key_reader

Interface
REQ-001 Parameter NBITS, default 16, is the number of key bits read after unlock; legal range 1..32.
REQ-002 Parameter CYC_LEN, default 4, is the number of clocks one bus read cycle is held active; legal range 2..15.
REQ-003 Parameter EXPECT, default 16'hA5C3 (NBITS wide), is the key value compared at completion.
REQ-004 Port clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 Port rst  in  1  synchronous, active-high reset.
REQ-006 Port start  in  1  request to run one key-read sequence; sampled every clock.
REQ-007 Port SSER  out  1  active-low select to the key responder.
REQ-008 Port BA13  out  1  address bit 13 of the responder window.
REQ-009 Port BA12  out  1  address bit 12 of the responder window.
REQ-010 Port BA_SEL  out  4  step code driven onto BA7..BA4 (bit 3 = BA7).
REQ-011 Port BR_W  out  1  bus direction, 1 = read.
REQ-012 Port SDRD  in  1  serial data bit returned by the responder.
REQ-013 Port busy  out  1  high while a sequence is in progress.
REQ-014 Port done  out  1  one-clock completion pulse.
REQ-015 Port match  out  1  key equals EXPECT; valid from done until next start accepted.
REQ-016 Port key  out  NBITS  assembled key, MSB received first.

Function
REQ-017 FSM states: IDLE, UNLOCK, READ, GAP, FINISH.
REQ-018 Idle bus: SSER=1, BA13=1, BA12=0, BA_SEL=0, BR_W=1.
REQ-019 Active bus cycle: SSER=0, BA13=0, BA12=1, BR_W=1, BA_SEL per step, held exactly CYC_LEN clocks.
REQ-020 Each active cycle is followed by exactly one GAP clock with idle bus values.
REQ-021 start in IDLE: key cleared to 0, match cleared, busy=1 and first UNLOCK cycle visible on the next clock.
REQ-022 UNLOCK issues four cycles, BA_SEL in order 4'b0010, 4'b1000, 4'b1010, 4'b1001; SDRD ignored.
REQ-023 READ issues NBITS cycles with BA_SEL=4'b0000.
REQ-024 On the last clock of each READ cycle, key <= {key[NBITS-2:0], SDRD}.
REQ-025 After the final GAP, FINISH for one clock: done=1, match=(key==EXPECT), busy=0 from the following clock; return to IDLE.
REQ-026 Latency: done asserts (4+NBITS)*(CYC_LEN+1)+1 clocks after start sampled; 101 with defaults.
REQ-027 start while busy or during FINISH is ignored; no queuing.
REQ-028 SDRD is not sampled outside READ; glitches in UNLOCK, GAP or IDLE have no effect.
REQ-029 All outputs are registered; no combinational path from SDRD or start to any output.

Reset
REQ-030 rst at any clock, including mid-cycle, forces IDLE on the next edge: idle bus values, busy=0, done=0, match=0, key=0.
REQ-031 rst has priority over start in the same clock; sequence counters restart from step 0 on the next start.

Configuration
REQ-032 Macro KEY_READER_RETRY_EN: when defined, a mismatch at FINISH suppresses done, clears key, and reruns UNLOCK+READ once after a GAP; done then pulses with the second result; a second mismatch ends with match=0.
REQ-033 Without KEY_READER_RETRY_EN, a mismatch ends the sequence immediately with done=1, match=0; ports identical in both builds.

Verification
REQ-034 Defaults, start pulse, SDRD model returning bits of 16'hA5C3 MSB-first during READ -> done at clock 101, key=16'hA5C3, match=1, busy low after.
REQ-035 Defaults, SDRD tied 0 -> key=16'h0000, match=0; with KEY_READER_RETRY_EN done at clock 201, without at clock 101.
REQ-036 Monitor BA_SEL on SSER-low cycles -> exactly 0010,1000,1010,1001 then sixteen 0000 cycles, each 4 clocks, 1 idle clock between.
REQ-037 rst asserted on clock 37 after start -> next clock SSER=1, BA12=0, busy=0, key=0; new start yields full 101-clock sequence.
REQ-038 start held high continuously -> one sequence per 102 clocks (restart only from IDLE), no start accepted while busy.
REQ-039 NBITS=1, CYC_LEN=2, SDRD=1 in READ, EXPECT=1 -> done at clock 16, key=1, match=1.
